grant_arbiter_8: RTL
====================

# grant_arbiter_8

Sequential 8-requester arbiter that shares one downstream resource (bus, port or datapath slot) among eight clients. Uses the team's 8-to-3 priority-encode scheme (bit 7 highest) to pick a winner, then holds the grant until release, owner request drop, or hold timeout. A one-cycle turnaround gap always separates two grants. Optional round-robin rotation gives fairness under sustained load.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles a grant may be held; legal range 2..255.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request vector; bit i = client i wants the resource; level-sensitive.
- `done`  in  1  current owner releases; single-cycle pulse; ignored when no grant is active.
- `grant`  out  8  one-hot grant vector; all-zero when idle or in gap.
- `grant_id`  out  3  binary index of current owner; valid only while `grant_valid`=1, otherwise 0.
- `grant_valid`  out  1  high while a grant is active; equals `|grant`.
- `timeout`  out  1  one-cycle pulse: grant was forcibly revoked by hold timeout.

## Operation
- FSM with 3 states: IDLE, GRANT, GAP.
- Reset values: state=IDLE, `grant`=0, `grant_id`=0, `grant_valid`=0, `timeout`=0, hold counter=0, rotation pointer `last_id`=0.
- IDLE or GAP, `req`≠0: select a winner, load `grant`/`grant_id`, clear the hold counter, go to GRANT.
- IDLE or GAP, `req`=0: go to IDLE, outputs 0.
- Winner selection, fixed mode: highest set index wins (7 > 6 > … > 0).
- GRANT: outputs held stable. Hold counter increments each cycle. It saturates at `MAX_HOLD`-1 and never wraps.
- GRANT exit, normal release: `done`=1, or the owner's `req` bit=0. Go to GAP with `timeout`=0.
- GRANT exit, timeout: counter = `MAX_HOLD`-1 and no normal release that cycle. Go to GAP with `timeout`=1.
- `done` and timeout in the same cycle: treated as normal release, so `timeout`=0.
- GAP: `grant`=0, `grant_valid`=0, `grant_id`=0. Lasts exactly one cycle. Arbitration is evaluated during GAP.
- `req` changes on non-owner bits during GRANT: no effect (no preemption).
- Reset asserted in any state: all outputs go to reset values immediately (asynchronous). Any in-flight grant is dropped with no `timeout` pulse.

## Timing
- Arbitration latency: `req` sampled at edge N in IDLE/GAP; `grant` is visible from edge N to edge N+1.
- Grant duration: minimum 1 cycle (`done` on the first grant cycle), maximum `MAX_HOLD` cycles.
- Release: `done` high at edge M causes `grant`=0 after edge M (GAP). The earliest next grant is after edge M+1.
- `timeout` is high during the GAP cycle that follows the forced release, for exactly one cycle.
- Back-to-back throughput: at most one grant per (hold + 1) cycles.
- All outputs are registered; there is no combinational path from `req`/`done` to any output.

## Configuration
- Macro `GRANT_ARBITER_ROUND_ROBIN_EN`.
- Defined: rotating priority.
  - After a grant to k, `last_id` is set to k.
  - The next search order is k-1, k-2, …, 0, 7, …, k (mod 8), so the previous owner becomes lowest priority.
  - With `last_id`=0 after reset, the search order is 7..0, identical to fixed mode.
- Undefined: fixed priority only. `last_id` is not implemented, and `grant_id` always follows the highest set `req` bit.

## Test plan
- Reset, then `req`=8'b0010_1100 → next cycle `grant`=8'b0010_0000, `grant_id`=5, `grant_valid`=1; outputs stable while `req[5]` is held.
- With `req`=8'b0000_1100 and owner 3, pulse `done` → one GAP cycle with `grant`=0, then `grant_id`=3 again in fixed mode (2 in round-robin).
- `MAX_HOLD`=16, `req`=8'h01 held, no `done` → `grant`=8'h01 for exactly 16 cycles, then GAP with `timeout`=1 for 1 cycle, then re-grant to 0.
- `req`=8'hFF constant, `done` on every grant cycle → fixed mode: `grant_id` = 7,7,7,…; round-robin: 7,6,5,4,3,2,1,0,7 with one gap cycle between each.
- Assert `rst` mid-GRANT (asynchronously, between edges) → `grant`=0, `grant_valid`=0, `grant_id`=0, `timeout`=0 immediately. After release, `req`=8'h80 → grant 7 one cycle later.
- `req`=0 with `done` pulses in IDLE → `grant_valid` stays 0, `timeout` stays 0, FSM remains IDLE.

Source files
------------

// File: rtl/grant_arbiter_8.sv
// rtl/grant_arbiter_8.sv - 8-requester hold/release arbiter with one-cycle turnaround gap.
// Define GRANT_ARBITER_ROUND_ROBIN_EN for rotating priority; default is fixed priority (bit 7 highest).
module grant_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_id_q, grant_id_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] win_id;
  logic       win_found;

`ifdef GRANT_ARBITER_ROUND_ROBIN_EN
  logic [2:0] last_id_q, last_id_d;

  // Search from last_id-1 downward with wrap, so the previous owner is tried last.
  always_comb begin
    win_id    = 3'd0;
    win_found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!win_found && req[last_id_q - 3'(i)]) begin
        win_id    = last_id_q - 3'(i);
        win_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_id    = 3'd0;
    win_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!win_found && req[i]) begin
        win_id    = 3'(i);
        win_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
`ifdef GRANT_ARBITER_ROUND_ROBIN_EN
    last_id_d  = last_id_q;
`endif
    case (state_q)
      ST_GRANT: begin
        if (done || !req[grant_id_q]) begin
          state_d    = ST_GAP;
          grant_d    = 8'd0;
          grant_id_d = 3'd0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_GAP;
          grant_d    = 8'd0;
          grant_id_d = 3'd0;
          timeout_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        if (win_found) begin
          state_d    = ST_GRANT;
          grant_d    = 8'd1 << win_id;
          grant_id_d = win_id;
          hold_cnt_d = 8'd0;
`ifdef GRANT_ARBITER_ROUND_ROBIN_EN
          last_id_d  = win_id;
`endif
        end else begin
          state_d    = ST_IDLE;
          grant_d    = 8'd0;
          grant_id_d = 3'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= 8'd0;
      grant_id_q <= 3'd0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
`ifdef GRANT_ARBITER_ROUND_ROBIN_EN
      last_id_q  <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef GRANT_ARBITER_ROUND_ROBIN_EN
      last_id_q  <= last_id_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule
